mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, number of cycles in WAIT without a response before a bus error is declared (must be >= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  EX result valid this cycle.
REQ-005 in_ready  output  1  stage can accept; combinationally 1 only in IDLE.
REQ-006 in_rd  input  5  destination register.
REQ-007 in_opr_b  input  32  store data (rs2).
REQ-008 in_opr_res  input  32  ALU result; byte address when in_dm_en=1.
REQ-009 in_lsuop  input  lsuop_t  LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-010 in_rf_en, in_dm_en  input  1 each  register-write enable, data-memory access enable.
REQ-011 in_wb_sel  input  2  writeback source select, passed through unchanged.
REQ-012 dbus_req_valid  output  1  request valid; dbus_req_ready  input  1  memory accepts.
REQ-013 dbus_we  output  1; dbus_addr  output  32 (bits[1:0]=0); dbus_wdata  output  32; dbus_be  output  4.
REQ-014 dbus_rsp_valid  input  1  response/acknowledge for loads and stores; dbus_rdata  input  32.
REQ-015 out_valid  output  1; out_rd  output  5; out_rf_en  output  1; out_wb_sel  output  2; out_alu_res  output  32; out_load_data  output  32.
REQ-016 misalign, bus_err  output  1 each  exception flags, valid only with out_valid.

Function
REQ-017 FSM SHALL have states IDLE, REQ, WAIT.
REQ-018 Transaction accepted on in_valid && in_ready; all in_* fields captured into an internal register that cycle.
REQ-019 Accepted op with dm_en=0: remain in IDLE; outputs registered, out_valid=1 next cycle; latency 1.
REQ-020 Accepted op with dm_en=1 and aligned address: go to REQ.
REQ-021 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus request, remain IDLE, next cycle out_valid=1, misalign=1, out_rf_en=0.
REQ-022 REQ: dbus_req_valid=1; address, we, be, wdata held stable until dbus_req_ready=1; then go to WAIT and clear the timeout counter.
REQ-023 WAIT: dbus_rsp_valid sampled only in WAIT; on rsp go to IDLE, out_valid=1 next cycle; dbus_rsp_valid in IDLE or REQ is ignored.
REQ-024 Timeout counter increments each WAIT cycle without rsp; when it reaches TIMEOUT_CYC: go to IDLE, next cycle out_valid=1, bus_err=1, out_rf_en=0.
REQ-025 Store lanes, a=addr[1:0]: SB be=0001<<a, wdata=byte replicated x4; SH be=0011<<a, wdata=halfword replicated x2; SW be=1111, wdata=opr_b.
REQ-026 Load extract: LB/LBU take rdata[8a+7:8a], LH/LHU take rdata[8a+15:8a]; sign-extend for LB/LH, zero-extend for LBU/LHU; LW=rdata.
REQ-027 out_load_data=0 for stores and non-memory ops; out_alu_res=captured opr_res always.
REQ-028 out_valid is a single-cycle pulse per accepted transaction; at most one transaction in flight.
REQ-029 Memory-op latency from acceptance to out_valid = 3 cycles + req-ready wait + rsp wait (min 3: accept, REQ with ready, WAIT with rsp).

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, dbus_req_valid=0, out_valid=0, misalign=0, bus_err=0, timeout counter=0, all out_* data=0.
REQ-031 Reset mid-REQ or mid-WAIT abandons the transaction; no out_valid is produced for it; a late dbus_rsp_valid after reset is ignored.

Verification
REQ-032 ALU op opr_res=0x1234, rd=5, rf_en=1, dm_en=0 -> next cycle out_valid=1, out_alu_res=0x1234, out_rd=5, no bus activity.
REQ-033 LB addr=0x103, rdata=0x80FFFFFF, ready immediate, rsp 2 cycles later -> out_load_data=0xFFFFFF80; with LBU -> 0x00000080.
REQ-034 SH addr=0x202, opr_b=0xDEADBEEF, ready held low 3 cycles -> dbus_addr=0x200, be=1100, wdata=0xBEEFBEEF stable throughout; in_ready=0 until completion.
REQ-035 LW addr=0x101 -> no dbus_req_valid; next cycle out_valid=1, misalign=1, out_rf_en=0.
REQ-036 LW with TIMEOUT_CYC=4, no response -> bus_err=1 with out_valid after 4 WAIT cycles; state IDLE and in_ready=1 following cycle.
REQ-037 rst asserted during WAIT, then rsp_valid pulses -> dbus_req_valid=0 immediately, no out_valid, next accepted op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Load/store stage: IDLE/REQ/WAIT FSM on a valid/ready data bus, one transaction in flight, bus-error timeout.
// Latency: 1 cycle for ALU/misaligned ops, 3+ cycles for memory ops; in_ready is low until the stage is back in IDLE.
module mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_opr_b,
    input  logic [31:0] in_opr_res,
    input  logic [2:0]  in_lsuop,
    input  logic        in_rf_en,
    input  logic        in_dm_en,
    input  logic [1:0]  in_wb_sel,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic        out_rf_en,
    output logic [1:0]  out_wb_sel,
    output logic [31:0] out_alu_res,
    output logic [31:0] out_load_data,
    output logic        misalign,
    output logic        bus_err
);
    localparam logic [2:0] LSU_LB = 3'd0, LSU_LH = 3'd1, LSU_LW = 3'd2, LSU_LBU = 3'd3,
                           LSU_LHU = 3'd4, LSU_SB = 3'd5, LSU_SH = 3'd6, LSU_SW = 3'd7;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t r_state, w_state_nxt;

    logic [4:0]    r_rd;
    logic [31:0]   r_opr_b, r_opr_res;
    logic [2:0]    r_lsuop;
    logic          r_rf_en, r_dm_en;
    logic [1:0]    r_wb_sel;
    logic [TW-1:0] r_tmo;

    logic        r_out_valid, r_out_rf_en, r_misalign, r_bus_err;
    logic [4:0]  r_out_rd;
    logic [1:0]  r_out_wb_sel;
    logic [31:0] r_out_alu_res, r_out_load_data;

    logic        w_accept, w_in_misalign, w_store, w_tmo_hit;
    logic [1:0]  w_a;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data, w_wdata;
    logic [3:0]  w_be;

    assign w_accept  = in_valid && in_ready;
    assign w_a       = r_opr_res[1:0];
    assign w_store   = (r_lsuop == LSU_SB) || (r_lsuop == LSU_SH) || (r_lsuop == LSU_SW);
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_in_misalign = 1'b0;
        if (in_dm_en) begin
            case (in_lsuop)
                LSU_LH, LSU_LHU, LSU_SH: w_in_misalign = in_opr_res[0];
                LSU_LW, LSU_SW:          w_in_misalign = (in_opr_res[1:0] != 2'b00);
                default:                 w_in_misalign = 1'b0;
            endcase
        end
    end

    // Store lane steering; loads request the full word and pick lanes on return.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'd0;
        case (r_lsuop)
            LSU_SB: begin w_be = 4'b0001 << w_a; w_wdata = {4{r_opr_b[7:0]}};  end
            LSU_SH: begin w_be = 4'b0011 << w_a; w_wdata = {2{r_opr_b[15:0]}}; end
            LSU_SW: begin w_be = 4'b1111;        w_wdata = r_opr_b;            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_a)
            2'd0:    w_byte = dbus_rdata[7:0];
            2'd1:    w_byte = dbus_rdata[15:8];
            2'd2:    w_byte = dbus_rdata[23:16];
            default: w_byte = dbus_rdata[31:24];
        endcase
        w_half = w_a[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (r_lsuop)
            LSU_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: w_load_data = {24'd0, w_byte};
            LSU_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            LSU_LHU: w_load_data = {16'd0, w_half};
            LSU_LW:  w_load_data = dbus_rdata;
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && in_dm_en && !w_in_misalign) w_state_nxt = S_REQ;
            S_REQ:   if (dbus_req_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (dbus_rsp_valid || w_tmo_hit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = (r_state == S_IDLE);
        dbus_req_valid = (r_state == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0; r_opr_b <= '0; r_opr_res <= '0; r_lsuop <= '0;
            r_rf_en <= 1'b0; r_dm_en <= 1'b0; r_wb_sel <= '0; r_tmo <= '0;
            r_out_valid <= 1'b0; r_out_rf_en <= 1'b0; r_misalign <= 1'b0; r_bus_err <= 1'b0;
            r_out_rd <= '0; r_out_wb_sel <= '0; r_out_alu_res <= '0; r_out_load_data <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_accept) begin
                r_rd <= in_rd; r_opr_b <= in_opr_b; r_opr_res <= in_opr_res; r_lsuop <= in_lsuop;
                r_rf_en <= in_rf_en; r_dm_en <= in_dm_en; r_wb_sel <= in_wb_sel;
                // Non-memory and misaligned ops retire straight from IDLE.
                if (!in_dm_en || w_in_misalign) begin
                    r_out_valid     <= 1'b1;
                    r_misalign      <= w_in_misalign;
                    r_out_rf_en     <= in_rf_en && !w_in_misalign;
                    r_out_rd        <= in_rd;
                    r_out_wb_sel    <= in_wb_sel;
                    r_out_alu_res   <= in_opr_res;
                    r_out_load_data <= 32'd0;
                end
            end
            if (r_state == S_REQ && dbus_req_ready) r_tmo <= '0;
            if (r_state == S_WAIT) begin
                if (dbus_rsp_valid || w_tmo_hit) begin
                    r_out_valid     <= 1'b1;
                    r_bus_err       <= !dbus_rsp_valid;
                    r_out_rf_en     <= r_rf_en && dbus_rsp_valid;
                    r_out_rd        <= r_rd;
                    r_out_wb_sel    <= r_wb_sel;
                    r_out_alu_res   <= r_opr_res;
                    r_out_load_data <= (dbus_rsp_valid && r_dm_en && !w_store) ? w_load_data : 32'd0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign dbus_we       = w_store;
    assign dbus_addr     = {r_opr_res[31:2], 2'b00};
    assign dbus_wdata    = w_wdata;
    assign dbus_be       = w_be;
    assign out_valid     = r_out_valid;
    assign out_rd        = r_out_rd;
    assign out_rf_en     = r_out_rf_en;
    assign out_wb_sel    = r_out_wb_sel;
    assign out_alu_res   = r_out_alu_res;
    assign out_load_data = r_out_load_data;
    assign misalign      = r_misalign;
    assign bus_err       = r_bus_err;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scripted memory-side handshakes, expected retirements queued at issue and checked on out_valid.
module tb_mem_stage;
    localparam logic [2:0] LSU_LB = 3'd0, LSU_LH = 3'd1, LSU_LW = 3'd2, LSU_LBU = 3'd3,
                           LSU_LHU = 3'd4, LSU_SB = 3'd5, LSU_SH = 3'd6, LSU_SW = 3'd7;

    logic        clk = 1'b0, rst;
    logic        in_valid, in_ready, in_rf_en, in_dm_en;
    logic [4:0]  in_rd;
    logic [31:0] in_opr_b, in_opr_res;
    logic [2:0]  in_lsuop;
    logic [1:0]  in_wb_sel;
    logic        dbus_req_valid, dbus_req_ready, dbus_we, dbus_rsp_valid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        out_valid, out_rf_en, misalign, bus_err;
    logic [4:0]  out_rd;
    logic [1:0]  out_wb_sel;
    logic [31:0] out_alu_res, out_load_data;

    typedef struct {
        logic [4:0]  rd;
        logic        rf_en;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        mis;
        logic        berr;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_opr_b(in_opr_b),
        .in_opr_res(in_opr_res), .in_lsuop(in_lsuop), .in_rf_en(in_rf_en), .in_dm_en(in_dm_en),
        .in_wb_sel(in_wb_sel),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
        .out_valid(out_valid), .out_rd(out_rd), .out_rf_en(out_rf_en), .out_wb_sel(out_wb_sel),
        .out_alu_res(out_alu_res), .out_load_data(out_load_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_rd",        32'(out_rd),     32'(e.rd));
                check("out_rf_en",     32'(out_rf_en),  32'(e.rf_en));
                check("out_wb_sel",    32'(out_wb_sel), 32'(e.wb));
                check("out_alu_res",   out_alu_res,     e.alu);
                check("out_load_data", out_load_data,   e.ld);
                check("misalign",      32'(misalign),   32'(e.mis));
                check("bus_err",       32'(bus_err),    32'(e.berr));
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic rf, input logic [1:0] wb,
                        input logic [31:0] alu, input logic [31:0] ld, input logic mis, input logic berr);
        exp_t e;
        e.rd = rd; e.rf_en = rf; e.wb = wb; e.alu = alu; e.ld = ld; e.mis = mis; e.berr = berr;
        sb_q.push_back(e);
    endtask

    // Drives one transaction; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic dm, input logic [31:0] res,
                         input logic [31:0] opb, input logic [4:0] rd, input logic rf, input logic [1:0] wb);
        int budget = 50;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("in_ready_wait_timeout", 32'd0, 32'd1);
        in_valid = 1'b1; in_lsuop = op; in_dm_en = dm; in_opr_res = res;
        in_opr_b = opb; in_rd = rd; in_rf_en = rf; in_wb_sel = wb;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic mem_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] opb,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                          input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_ld);
        push(5'd7, !exp_we, 2'b01, addr, exp_ld, 1'b0, 1'b0);
        issue(op, 1'b1, addr, opb, 5'd7, !exp_we, 2'b01);
        for (int i = 0; i <= rdy_dly; i++) begin
            check("req_valid", 32'(dbus_req_valid), 32'd1);
            check("req_addr",  dbus_addr, {addr[31:2], 2'b00});
            check("req_we",    32'(dbus_we), 32'(exp_we));
            check("in_ready_busy", 32'(in_ready), 32'd0);
            if (exp_we) begin
                check("req_be",    32'(dbus_be), 32'(exp_be));
                check("req_wdata", dbus_wdata, exp_wdata);
            end
            dbus_req_ready = (i == rdy_dly);
            @(posedge clk); #1;
        end
        dbus_req_ready = 1'b0;
        for (int j = 0; j <= rsp_dly; j++) begin
            check("wait_req_valid", 32'(dbus_req_valid), 32'd0);
            check("wait_out_valid", 32'(out_valid), 32'd0);
            dbus_rsp_valid = (j == rsp_dly);
            dbus_rdata     = (j == rsp_dly) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        dbus_rsp_valid = 1'b0;
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_opr_b = '0; in_opr_res = '0; in_lsuop = '0;
        in_rf_en = 1'b0; in_dm_en = 1'b0; in_wb_sel = '0;
        dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rdata = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(dbus_req_valid), 32'd0);
        check("rst_misalign",  32'(misalign), 32'd0);
        check("rst_bus_err",   32'(bus_err), 32'd0);
        check("rst_alu_res",   out_alu_res, 32'd0);
        check("rst_load_data", out_load_data, 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through, latency 1
        push(5'd5, 1'b1, 2'b10, 32'h1234, 32'd0, 1'b0, 1'b0);
        issue(LSU_LW, 1'b0, 32'h1234, 32'hFFFF_FFFF, 5'd5, 1'b1, 2'b10);
        check("alu_out_valid", 32'(out_valid), 32'd1);
        check("alu_no_bus",    32'(dbus_req_valid), 32'd0);
        @(posedge clk); #1;
        check("alu_pulse", 32'(out_valid), 32'd0);

        mem_op(LSU_LB,  32'h103, 32'd0, 32'h80FF_FFFF, 0, 2, 1'b0, 4'b0, 32'd0, 32'hFFFF_FF80);
        mem_op(LSU_LBU, 32'h103, 32'd0, 32'h80FF_FFFF, 0, 2, 1'b0, 4'b0, 32'd0, 32'h0000_0080);
        mem_op(LSU_SH,  32'h202, 32'hDEAD_BEEF, 32'd0, 3, 0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        mem_op(LSU_SB,  32'h101, 32'h1234_56A5, 32'd0, 1, 1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'd0);
        mem_op(LSU_SW,  32'h108, 32'h1122_3344, 32'd0, 0, 0, 1'b1, 4'b1111, 32'h1122_3344, 32'd0);
        mem_op(LSU_LH,  32'h102, 32'd0, 32'h8001_1234, 0, 1, 1'b0, 4'b0, 32'd0, 32'hFFFF_8001);
        mem_op(LSU_LHU, 32'h102, 32'd0, 32'h8001_1234, 2, 0, 1'b0, 4'b0, 32'd0, 32'h0000_8001);
        mem_op(LSU_LW,  32'h104, 32'd0, 32'hCAFE_F00D, 0, 3, 1'b0, 4'b0, 32'd0, 32'hCAFE_F00D);

        // Misaligned accesses retire at once with rf_en cleared
        push(5'd3, 1'b0, 2'b01, 32'h101, 32'd0, 1'b1, 1'b0);
        issue(LSU_LW, 1'b1, 32'h101, 32'd0, 5'd3, 1'b1, 2'b01);
        check("mis_lw_no_req", 32'(dbus_req_valid), 32'd0);
        check("mis_lw_valid",  32'(out_valid), 32'd1);
        push(5'd4, 1'b0, 2'b01, 32'h203, 32'd0, 1'b1, 1'b0);
        issue(LSU_SH, 1'b1, 32'h203, 32'h55, 5'd4, 1'b1, 2'b01);
        check("mis_sh_no_req", 32'(dbus_req_valid), 32'd0);
        push(5'd6, 1'b0, 2'b00, 32'h105, 32'd0, 1'b1, 1'b0);
        issue(LSU_LHU, 1'b1, 32'h105, 32'd0, 5'd6, 1'b1, 2'b00);
        check("mis_lhu_no_req", 32'(dbus_req_valid), 32'd0);
        @(posedge clk); #1;

        // Timeout after 4 silent WAIT cycles
        push(5'd7, 1'b0, 2'b01, 32'h300, 32'd0, 1'b0, 1'b1);
        issue(LSU_LW, 1'b1, 32'h300, 32'd0, 5'd7, 1'b1, 2'b01);
        check("tmo_req_valid", 32'(dbus_req_valid), 32'd1);
        dbus_req_ready = 1'b1;
        @(posedge clk); #1;
        dbus_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("tmo_early_valid", 32'(out_valid), 32'd0);
            check("tmo_in_ready",    32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("tmo_out_valid", 32'(out_valid), 32'd1);
        check("tmo_idle",      32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Reset during REQ drops the request immediately
        issue(LSU_SW, 1'b1, 32'h500, 32'h1, 5'd2, 1'b0, 2'b00);
        check("rreq_req_valid", 32'(dbus_req_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rreq_drop", 32'(dbus_req_valid), 32'd0);
        check("rreq_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Reset during WAIT, then a late response must be ignored
        issue(LSU_LW, 1'b1, 32'h400, 32'd0, 5'd2, 1'b1, 2'b00);
        dbus_req_ready = 1'b1;
        @(posedge clk); #1;
        dbus_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rwait_req_valid", 32'(dbus_req_valid), 32'd0);
        check("rwait_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        dbus_rsp_valid = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0;
        check("late_rsp_ignored", 32'(out_valid), 32'd0);
        check("late_rsp_idle",    32'(in_ready), 32'd1);
        repeat (2) @(posedge clk); #1;
        mem_op(LSU_LW, 32'h104, 32'd0, 32'h0BAD_CAFE, 1, 1, 1'b0, 4'b0, 32'd0, 32'h0BAD_CAFE);

        repeat (3) @(posedge clk); #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
